// File: rtl/sap_ctrl_seq_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: opcodes, T-state bit
// positions, the active-high internal control word and the decoded instruction class.
package sap_ctrl_seq_pkg;

    localparam int T_STATES = 6;
    localparam int T1_BIT = 0;
    localparam int T2_BIT = 1;
    localparam int T3_BIT = 2;
    localparam int T4_BIT = 3;
    localparam int T5_BIT = 4;
    localparam int T6_BIT = 5;

    localparam logic [T_STATES-1:0] T1_ONEHOT = 6'b000001;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Internal control word is active-high; the top inverts the bus enables.
    typedef struct packed {
        logic pc_inc;
        logic pc_o;
        logic mar_i;
        logic ram_o;
        logic ir_i;
        logic ir_o;
        logic a_i;
        logic a_o;
        logic b_i;
        logic out_i;
        logic alu_o;
        logic alu_sub;
    } ctrl_word_t;

    localparam ctrl_word_t CW_IDLE = '0;

    typedef enum logic [2:0] {
        INS_LDA,
        INS_ADD,
        INS_SUB,
        INS_OUT,
        INS_HLT,
        INS_NOP
    } instr_e;

    function automatic logic instr_halts(instr_e ins);
        return ins == INS_HLT;
    endfunction

endpackage

// File: rtl/sap_ctrl_seq_if.sv
// Control bus between the SAP-1 sequencer (master) and the datapath registers
// it enables (slave); the IR opcode nibble travels back to the sequencer.
interface sap_ctrl_seq_if #(
    parameter int OPCODE_WIDTH = 4
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [5:0]              t_state;
    logic                    pc_inc;
    logic                    low_pc_o_en;
    logic                    low_mar_i_en;
    logic                    low_ram_o_en;
    logic                    low_ir_i_en;
    logic                    low_ir_o_en;
    logic                    low_a_i_en;
    logic                    low_a_o_en;
    logic                    low_b_i_en;
    logic                    low_out_i_en;
    logic                    low_alu_o_en;
    logic                    alu_sub;
    logic                    halted;

    modport master (
        input  opcode,
        output t_state, pc_inc, low_pc_o_en, low_mar_i_en, low_ram_o_en,
               low_ir_i_en, low_ir_o_en, low_a_i_en, low_a_o_en, low_b_i_en,
               low_out_i_en, low_alu_o_en, alu_sub, halted
    );

    modport slave (
        output opcode,
        input  t_state, pc_inc, low_pc_o_en, low_mar_i_en, low_ram_o_en,
               low_ir_i_en, low_ir_o_en, low_a_i_en, low_a_o_en, low_b_i_en,
               low_out_i_en, low_alu_o_en, alu_sub, halted
    );
endinterface

// File: rtl/sap_ctrl_seq_ring_counter.sv
// Six-state one-hot T-state ring. Priority: reset, then hold (halt), then
// restart-to-T1 (early instruction end), then normal rotation.
module sap_ring_counter
    import sap_ctrl_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic                restart,
    output logic [T_STATES-1:0] t_state
);

    logic [T_STATES-1:0] ring_q;
    logic [T_STATES-1:0] ring_d;

    always_comb begin
        ring_d = {ring_q[T_STATES-2:0], ring_q[T_STATES-1]};
        if (hold) begin
            ring_d = ring_q;
        end else if (restart) begin
            ring_d = T1_ONEHOT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ring_q <= T1_ONEHOT;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign t_state = ring_q;

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP-1 controller-sequencer: opcode decode, control-word mux and halt flop.
// Build option SAP_CTRL_VARIABLE_CYCLE_EN ends each instruction after its last active T-state.
module sap_ctrl_seq
    import sap_ctrl_seq_pkg::*;
#(
    parameter int OPCODE_WIDTH    = 4,
    parameter bit HALT_ON_UNKNOWN = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    sap_ctrl_seq_if.master bus
);

    logic [T_STATES-1:0] t_state;
    logic                hold;
    logic                restart;
    logic                halt_now;
    logic                halted_q;
    logic                halted_d;
    instr_e              instr;
    ctrl_word_t          cw;

    sap_ring_counter u_ring (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold),
        .restart (restart),
        .t_state (t_state)
    );

    always_comb begin
        instr = HALT_ON_UNKNOWN ? INS_HLT : INS_NOP;
        if (bus.opcode == OPCODE_WIDTH'(OP_LDA)) instr = INS_LDA;
        else if (bus.opcode == OPCODE_WIDTH'(OP_ADD)) instr = INS_ADD;
        else if (bus.opcode == OPCODE_WIDTH'(OP_SUB)) instr = INS_SUB;
        else if (bus.opcode == OPCODE_WIDTH'(OP_OUT)) instr = INS_OUT;
        else if (bus.opcode == OPCODE_WIDTH'(OP_HLT)) instr = INS_HLT;
    end

    // The opcode is only valid once the IR has loaded, so halting is decided in T4
    // and the ring is held there from that edge on.
    always_comb begin
        halt_now = t_state[T4_BIT] & instr_halts(instr) & ~halted_q;
        halted_d = halted_q | halt_now;
        hold     = halted_q | halt_now;
    end

`ifdef SAP_CTRL_VARIABLE_CYCLE_EN
    // NOP cannot be recognised before T4 (the IR is still loading in T3), so it ends after an idle T4.
    always_comb begin
        restart = 1'b0;
        if (t_state[T5_BIT] && instr == INS_LDA) restart = 1'b1;
        if (t_state[T4_BIT] && (instr == INS_OUT || instr == INS_NOP)) restart = 1'b1;
    end
`else
    always_comb begin
        restart = 1'b0;
    end
`endif

    always_comb begin
        cw = CW_IDLE;
        if (!reset && !halted_q) begin
            if (t_state[T1_BIT]) begin
                cw.pc_o  = 1'b1;
                cw.mar_i = 1'b1;
            end else if (t_state[T2_BIT]) begin
                cw.pc_inc = 1'b1;
            end else if (t_state[T3_BIT]) begin
                cw.ram_o = 1'b1;
                cw.ir_i  = 1'b1;
            end else if (t_state[T4_BIT]) begin
                if (instr == INS_LDA || instr == INS_ADD || instr == INS_SUB) begin
                    cw.ir_o  = 1'b1;
                    cw.mar_i = 1'b1;
                end else if (instr == INS_OUT) begin
                    cw.a_o   = 1'b1;
                    cw.out_i = 1'b1;
                end
            end else if (t_state[T5_BIT]) begin
                if (instr == INS_LDA) begin
                    cw.ram_o = 1'b1;
                    cw.a_i   = 1'b1;
                end else if (instr == INS_ADD || instr == INS_SUB) begin
                    cw.ram_o   = 1'b1;
                    cw.b_i     = 1'b1;
                    cw.alu_sub = (instr == INS_SUB);
                end
            end else if (t_state[T6_BIT]) begin
                if (instr == INS_ADD || instr == INS_SUB) begin
                    cw.alu_o   = 1'b1;
                    cw.a_i     = 1'b1;
                    cw.alu_sub = (instr == INS_SUB);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign bus.t_state      = t_state;
    assign bus.pc_inc       = cw.pc_inc;
    assign bus.low_pc_o_en  = ~cw.pc_o;
    assign bus.low_mar_i_en = ~cw.mar_i;
    assign bus.low_ram_o_en = ~cw.ram_o;
    assign bus.low_ir_i_en  = ~cw.ir_i;
    assign bus.low_ir_o_en  = ~cw.ir_o;
    assign bus.low_a_i_en   = ~cw.a_i;
    assign bus.low_a_o_en   = ~cw.a_o;
    assign bus.low_b_i_en   = ~cw.b_i;
    assign bus.low_out_i_en = ~cw.out_i;
    assign bus.low_alu_o_en = ~cw.alu_o;
    assign bus.alu_sub      = cw.alu_sub;
    assign bus.halted       = halted_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Randomised bench for sap_ctrl_seq: a per-cycle instruction-level model feeds a
// scoreboard queue that a separate monitor drains and compares.
module tb_sap_ctrl_seq;

    localparam bit HOU = 1'b0;

    localparam logic [11:0] M_PC_INC  = 12'h800;
    localparam logic [11:0] M_PC_O    = 12'h400;
    localparam logic [11:0] M_MAR_I   = 12'h200;
    localparam logic [11:0] M_RAM_O   = 12'h100;
    localparam logic [11:0] M_IR_I    = 12'h080;
    localparam logic [11:0] M_IR_O    = 12'h040;
    localparam logic [11:0] M_A_I     = 12'h020;
    localparam logic [11:0] M_A_O     = 12'h010;
    localparam logic [11:0] M_B_I     = 12'h008;
    localparam logic [11:0] M_OUT_I   = 12'h004;
    localparam logic [11:0] M_ALU_O   = 12'h002;
    localparam logic [11:0] M_ALU_SUB = 12'h001;

    typedef struct {
        logic [5:0]  t;
        logic [11:0] cw;
        logic        halted;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_step = 1;
    bit   m_halted = 1'b0;

    sap_ctrl_seq_if #(.OPCODE_WIDTH(4)) bus ();

    sap_ctrl_seq #(
        .OPCODE_WIDTH    (4),
        .HALT_ON_UNKNOWN (HOU)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit halts(logic [3:0] op);
        return (op == 4'hF) || (HOU && !(op inside {4'h0, 4'h1, 4'h2, 4'hE}));
    endfunction

    function automatic int instr_len(logic [3:0] op);
`ifdef SAP_CTRL_VARIABLE_CYCLE_EN
        case (op)
            4'h0:       return 5;
            4'h1, 4'h2: return 6;
            default:    return 4;
        endcase
`else
        return 6;
`endif
    endfunction

    // Micro-operations of each instruction, listed per T-state.
    function automatic logic [11:0] exp_word(int step, logic [3:0] op, bit halted, bit rst);
        logic [11:0] w;
        w = '0;
        if (rst || halted) return w;
        case (step)
            1: w = M_PC_O | M_MAR_I;
            2: w = M_PC_INC;
            3: w = M_RAM_O | M_IR_I;
            default: begin
                case (op)
                    4'h0: begin
                        if (step == 4) w = M_IR_O | M_MAR_I;
                        if (step == 5) w = M_RAM_O | M_A_I;
                    end
                    4'h1, 4'h2: begin
                        if (step == 4) w = M_IR_O | M_MAR_I;
                        if (step == 5) w = M_RAM_O | M_B_I | ((op == 4'h2) ? M_ALU_SUB : 12'h000);
                        if (step == 6) w = M_ALU_O | M_A_I | ((op == 4'h2) ? M_ALU_SUB : 12'h000);
                    end
                    4'hE: begin
                        if (step == 4) w = M_A_O | M_OUT_I;
                    end
                    default: w = '0;
                endcase
            end
        endcase
        return w;
    endfunction

    task automatic cycle(input logic r, input logic [3:0] op);
        exp_t e;
        @(negedge clk);
        reset = r;
        bus.opcode = op;
        e.t = 6'(1 << (m_step - 1));
        e.cw = exp_word(m_step, op, m_halted, r);
        e.halted = m_halted;
        sb_q.push_back(e);
        if (r) begin
            m_step = 1;
            m_halted = 1'b0;
        end else if (m_halted) begin
            m_step = 4;
        end else if (m_step == 4 && halts(op)) begin
            m_halted = 1'b1;
        end else if (m_step >= instr_len(op)) begin
            m_step = 1;
        end else begin
            m_step++;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input int rst_at);
        int n;
        logic r;
        logic [3:0] o;
        n = 0;
        do begin
            r = (rst_at != 0 && m_step == rst_at);
            o = (m_step < 4) ? 4'($urandom) : op;
            cycle(r, o);
            n++;
        end while (m_step != 1 && n < 30);
        if (m_halted) cycle(1'b1, 4'($urandom));
    endtask

    initial begin
        exp_t e;
        logic [11:0] act;
        int n_oe;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {bus.pc_inc, ~bus.low_pc_o_en, ~bus.low_mar_i_en, ~bus.low_ram_o_en,
                       ~bus.low_ir_i_en, ~bus.low_ir_o_en, ~bus.low_a_i_en, ~bus.low_a_o_en,
                       ~bus.low_b_i_en, ~bus.low_out_i_en, ~bus.low_alu_o_en, bus.alu_sub};
                checks++;
                if (bus.t_state !== e.t) begin
                    errors++;
                    $display("FAIL t_state @%0t: got %b expected %b", $time, bus.t_state, e.t);
                end
                checks++;
                if (act !== e.cw) begin
                    errors++;
                    $display("FAIL ctrl_word @%0t: got %b expected %b", $time, act, e.cw);
                end
                checks++;
                if (bus.halted !== e.halted) begin
                    errors++;
                    $display("FAIL halted @%0t: got %b expected %b", $time, bus.halted, e.halted);
                end
                n_oe = int'(bus.low_pc_o_en === 1'b0) + int'(bus.low_ram_o_en === 1'b0) +
                       int'(bus.low_ir_o_en === 1'b0) + int'(bus.low_a_o_en === 1'b0) +
                       int'(bus.low_alu_o_en === 1'b0);
                checks++;
                if (n_oe > 1) begin
                    errors++;
                    $display("FAIL bus_contention @%0t: got %0d drivers expected at most 1", $time, n_oe);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] op;
        int rst_at;
        reset = 1'b1;
        bus.opcode = 4'h0;
        @(posedge clk);
        cycle(1'b1, 4'h0);
        run_instr(4'h0, 0);
        run_instr(4'h2, 0);
        run_instr(4'h1, 5);
        run_instr(4'h1, 0);
        run_instr(4'hE, 0);
        run_instr(4'h7, 0);
        run_instr(4'hF, 0);
        run_instr(4'h2, 3);
        run_instr(4'h0, 0);
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_instr(op, rst_at);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
